reg_wb_scheduler: RTL and testbench
===================================

# reg_wb_scheduler

Write-back scheduler for the 32×32 register file's single write port. Arbitrates between the single-cycle ALU result path (source A) and the multi-cycle load/multiply-divide path (source B) with round-robin fairness. Drives the register file write port through one output register stage. Keeps a 32-bit pending-write scoreboard so decode can stall on RAW/WAW hazards against long-latency results.

## Interface
- `DATA_W`, 32, write data width
- `ADDR_W`, 5, register address width (32 registers)
- `SYS_clk`  in  1  system clock, all state updates on rising edge
- `SYS_reset`  in  1  synchronous, active-high reset
- `WB_a_valid`  in  1  source A (ALU) write request
- `WB_a_addr`  in  ADDR_W  source A destination register
- `WB_a_data`  in  DATA_W  source A write data
- `WB_a_ready`  out  1  source A request accepted this cycle
- `WB_b_valid`, `WB_b_addr`, `WB_b_data`, `WB_b_ready`: same as source A, for source B (load/MDU)
- `ISS_set`  in  1  a long-latency op targeting `ISS_addr` issues this cycle
- `ISS_addr`  in  ADDR_W  destination of the issuing long-latency op
- `HZ_addr1`, `HZ_addr2`  in  ADDR_W  decode source operands to check
- `HZ_addr3`  in  ADDR_W  decode destination to check (WAW)
- `HZ_stall`  out  1  combinational hazard flag
- `REG_write_1`  out  1  register file write enable (registered)
- `REG_address_wr`  out  ADDR_W  register file write address (registered)
- `REG_data_wb_in1`  out  DATA_W  register file write data (registered)

## Operation
- Handshake: a request transfers on a rising edge where valid && ready. The requester holds valid, addr and data stable until ready.
- Arbitration:
  - `WB_a_ready = !SYS_reset && (!WB_b_valid || pref==A)`
  - `WB_b_ready = !SYS_reset && (!WB_a_valid || pref==B)`
  - Exactly one grant per cycle when both sources are valid.
- Round-robin pointer `pref`:
  - Moves to the other source after a cycle in which both were valid.
  - Unchanged when zero or one source is valid.
  - Reset value: A.
- Output stage:
  - On accept, the output stage loads the granted addr and data.
  - `REG_write_1 = 1` only if the granted addr != 0. Writes to $0 are accepted and discarded.
  - With no accept, `REG_write_1 = 0`. Addr and data hold their last values.
- Scoreboard `pend[31:0]`:
  - `ISS_set` with `ISS_addr != 0` sets `pend[ISS_addr]`.
  - An accepted source-B transfer clears `pend[WB_b_addr]`.
  - Same-cycle set and clear of the same address: set wins, because the newer op is outstanding.
  - `pend[0]` is always 0.
- `HZ_stall` is 1 if any of `HZ_addr1/2/3` (nonzero) either:
  - has its `pend` bit set, or
  - equals `REG_address_wr` while `REG_write_1 = 1` (write not yet visible to the combinational read).
- Reset:
  - `pend` = 0, `pref` = A.
  - `REG_write_1` = 0, `REG_address_wr` = 0, `REG_data_wb_in1` = 0.
  - Both readies are 0 during reset.
  - Reset mid-operation drops the in-flight output stage and all pending bits. There is no replay.

## Timing
- Latency: accept on edge N → `REG_write_1` high in cycle N+1 → register file updated on edge N+1. A read in cycle N+2 sees the new value.
- Throughput: one write per cycle. Under contention each source gets ≥1 grant every 2 cycles.
- Ready depends combinationally on the other source's valid and on `pref` only, never on its own valid.
- `HZ_stall` is combinational from the `HZ_*` inputs, `pend` and the output stage. It has no path from `WB_*_valid`.

## Structure
- Package `reg_wb_pkg`:
  - `DATA_W`, `ADDR_W`, `NUM_REGS` = 32
  - enum `wb_src_t {SRC_A, SRC_B}` for `pref` and grant
  - constant `REG_ZERO` = 0
- Sub-module `reg_scoreboard`: `pend` vector, set/clear logic, hazard compare. The arbiter and output stage stay in the top module.

## Test plan
- Reset held 2 cycles, then released → all outputs 0, `pend` = 0, first contended grant goes to A.
- A and B valid continuously for 4 cycles, A addr 3 / data 0x11, B addr 4 / data 0x22 → grants A,B,A,B; `REG_write_1` high for 4 consecutive cycles, each starting one cycle after its accept.
- A-only write, addr 0, data 0xFFFF_FFFF → `WB_a_ready` = 1, `REG_write_1` stays 0.
- `ISS_set` addr 7 → `HZ_stall` = 1 for `HZ_addr1` = 7. B write to 7 accepted on edge N → stall persists through cycle N+1 (output stage match) and drops in N+2.
- Same cycle: `ISS_set` addr 9 and B accepted to addr 9 → `pend[9]` remains 1.
- `SYS_reset` asserted while an output write is pending and `pend[5]` = 1 → next cycle `REG_write_1` = 0 and `pend` = 0.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared widths, source encoding and constants for the register write-back scheduler.
package reg_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } wb_src_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for long-latency results plus the decode hazard compare.
module reg_scoreboard
    import reg_wb_pkg::*;
#(
    parameter int ADDR_W = reg_wb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] hz_addr1,
    input  logic [ADDR_W-1:0] hz_addr2,
    input  logic [ADDR_W-1:0] hz_addr3,
    output logic              stall
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;

    // Set is applied after clear so a newly issued op to the same register stays outstanding.
    always_comb begin
        pend_nxt = pend;
        if (clr_en) begin
            pend_nxt[clr_addr] = 1'b0;
        end
        if (set_en && (set_addr != REG_ZERO)) begin
            pend_nxt[set_addr] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    // The output-stage write lands on the next edge, so a same-cycle read would still see stale data.
    function automatic logic hazard(input logic [ADDR_W-1:0] addr);
        return (addr != REG_ZERO) && (pend[addr] || (wr_en && (wr_addr == addr)));
    endfunction

    assign stall = hazard(hz_addr1) || hazard(hz_addr2) || hazard(hz_addr3);

endmodule

// File: rtl/reg_wb_scheduler.sv
// Round-robin arbiter between ALU and load/MDU results feeding a registered register-file write port.
module reg_wb_scheduler
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = reg_wb_pkg::DATA_W,
    parameter int ADDR_W = reg_wb_pkg::ADDR_W
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              WB_a_valid,
    input  logic [ADDR_W-1:0] WB_a_addr,
    input  logic [DATA_W-1:0] WB_a_data,
    output logic              WB_a_ready,
    input  logic              WB_b_valid,
    input  logic [ADDR_W-1:0] WB_b_addr,
    input  logic [DATA_W-1:0] WB_b_data,
    output logic              WB_b_ready,
    input  logic              ISS_set,
    input  logic [ADDR_W-1:0] ISS_addr,
    input  logic [ADDR_W-1:0] HZ_addr1,
    input  logic [ADDR_W-1:0] HZ_addr2,
    input  logic [ADDR_W-1:0] HZ_addr3,
    output logic              HZ_stall,
    output logic              REG_write_1,
    output logic [ADDR_W-1:0] REG_address_wr,
    output logic [DATA_W-1:0] REG_data_wb_in1
);

    wb_src_t pref;
    wb_src_t pref_nxt;
    logic    a_acc;
    logic    b_acc;

    // Ready looks only at the other source's valid, so neither requester sees a loop through itself.
    assign WB_a_ready = !SYS_reset && (!WB_b_valid || (pref == SRC_A));
    assign WB_b_ready = !SYS_reset && (!WB_a_valid || (pref == SRC_B));
    assign a_acc      = WB_a_valid && WB_a_ready;
    assign b_acc      = WB_b_valid && WB_b_ready;

    always_comb begin
        pref_nxt = pref;
        if (WB_a_valid && WB_b_valid) begin
            pref_nxt = (pref == SRC_A) ? SRC_B : SRC_A;
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            pref <= SRC_A;
        end else begin
            pref <= pref_nxt;
        end
    end

    // Writes to register 0 are consumed but never reach the register file.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            REG_write_1     <= 1'b0;
            REG_address_wr  <= '0;
            REG_data_wb_in1 <= '0;
        end else if (a_acc) begin
            REG_write_1     <= (WB_a_addr != REG_ZERO);
            REG_address_wr  <= WB_a_addr;
            REG_data_wb_in1 <= WB_a_data;
        end else if (b_acc) begin
            REG_write_1     <= (WB_b_addr != REG_ZERO);
            REG_address_wr  <= WB_b_addr;
            REG_data_wb_in1 <= WB_b_data;
        end else begin
            REG_write_1     <= 1'b0;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (SYS_clk),
        .reset    (SYS_reset),
        .set_en   (ISS_set),
        .set_addr (ISS_addr),
        .clr_en   (b_acc),
        .clr_addr (WB_b_addr),
        .wr_en    (REG_write_1),
        .wr_addr  (REG_address_wr),
        .hz_addr1 (HZ_addr1),
        .hz_addr2 (HZ_addr2),
        .hz_addr3 (HZ_addr3),
        .stall    (HZ_stall)
    );

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed and randomized checks of reg_wb_scheduler against a behavioural model of the write-back rules.
module tb_reg_wb_scheduler;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        WB_a_valid;
    logic [4:0]  WB_a_addr;
    logic [31:0] WB_a_data;
    logic        WB_a_ready;
    logic        WB_b_valid;
    logic [4:0]  WB_b_addr;
    logic [31:0] WB_b_data;
    logic        WB_b_ready;
    logic        ISS_set;
    logic [4:0]  ISS_addr;
    logic [4:0]  HZ_addr1;
    logic [4:0]  HZ_addr2;
    logic [4:0]  HZ_addr3;
    logic        HZ_stall;
    logic        REG_write_1;
    logic [4:0]  REG_address_wr;
    logic [31:0] REG_data_wb_in1;

    always #5 SYS_clk = ~SYS_clk;

    reg_wb_scheduler dut (
        .SYS_clk         (SYS_clk),
        .SYS_reset       (SYS_reset),
        .WB_a_valid      (WB_a_valid),
        .WB_a_addr       (WB_a_addr),
        .WB_a_data       (WB_a_data),
        .WB_a_ready      (WB_a_ready),
        .WB_b_valid      (WB_b_valid),
        .WB_b_addr       (WB_b_addr),
        .WB_b_data       (WB_b_data),
        .WB_b_ready      (WB_b_ready),
        .ISS_set         (ISS_set),
        .ISS_addr        (ISS_addr),
        .HZ_addr1        (HZ_addr1),
        .HZ_addr2        (HZ_addr2),
        .HZ_addr3        (HZ_addr3),
        .HZ_stall        (HZ_stall),
        .REG_write_1     (REG_write_1),
        .REG_address_wr  (REG_address_wr),
        .REG_data_wb_in1 (REG_data_wb_in1)
    );

    int checks = 0;
    int errors = 0;
    int cycleNo = 0;

    // Reference model: outstanding long-latency destinations, whose turn it is, last write seen by the register file.
    bit          mPend [32];
    bit          mTurnB = 1'b0;
    bit          mWr = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;
    bit          lastAccA = 1'b0;
    bit          lastAccB = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: observed %h expected %h", tag, cycleNo, observed, expected);
        end
    endtask

    function automatic bit modelHazard(input logic [4:0] addr);
        if (addr == 5'd0) return 1'b0;
        return mPend[addr] || (mWr && (mAddr == addr));
    endfunction

    task automatic applyStimulus(input bit rst,
                                 input bit av, input logic [4:0] aa, input logic [31:0] ad,
                                 input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                                 input bit iss, input logic [4:0] ia,
                                 input logic [4:0] h1, input logic [4:0] h2, input logic [4:0] h3);
        bit expARdy;
        bit expBRdy;
        bit expStall;
        @(negedge SYS_clk);
        SYS_reset  = rst;
        WB_a_valid = av;
        WB_a_addr  = aa;
        WB_a_data  = ad;
        WB_b_valid = bv;
        WB_b_addr  = ba;
        WB_b_data  = bd;
        ISS_set    = iss;
        ISS_addr   = ia;
        HZ_addr1   = h1;
        HZ_addr2   = h2;
        HZ_addr3   = h3;
        #1;
        expARdy  = !rst && (!bv || !mTurnB);
        expBRdy  = !rst && (!av || mTurnB);
        expStall = modelHazard(h1) || modelHazard(h2) || modelHazard(h3);
        checkOutput("a_ready", 32'(WB_a_ready), 32'(expARdy));
        checkOutput("b_ready", 32'(WB_b_ready), 32'(expBRdy));
        checkOutput("hz_stall", 32'(HZ_stall), 32'(expStall));
        checkOutput("reg_write", 32'(REG_write_1), 32'(mWr));
        checkOutput("reg_addr", 32'(REG_address_wr), 32'(mAddr));
        checkOutput("reg_data", REG_data_wb_in1, mData);
        lastAccA = av && expARdy;
        lastAccB = bv && expBRdy && !lastAccA;
        @(posedge SYS_clk);
        cycleNo++;
        if (rst) begin
            foreach (mPend[i]) mPend[i] = 1'b0;
            mTurnB = 1'b0;
            mWr    = 1'b0;
            mAddr  = '0;
            mData  = '0;
        end else begin
            if (lastAccA) begin
                mWr   = (aa != 5'd0);
                mAddr = aa;
                mData = ad;
            end else if (lastAccB) begin
                mWr   = (ba != 5'd0);
                mAddr = ba;
                mData = bd;
                mPend[ba] = 1'b0;
            end else begin
                mWr = 1'b0;
            end
            if (iss && (ia != 5'd0)) mPend[ia] = 1'b1;
            if (av && bv) mTurnB = !mTurnB;
        end
    endtask

    bit          rav = 1'b0;
    logic [4:0]  raa = '0;
    logic [31:0] rad = '0;
    bit          rbv = 1'b0;
    logic [4:0]  rba = '0;
    logic [31:0] rbd = '0;

    initial begin
        foreach (mPend[i]) mPend[i] = 1'b0;
        SYS_reset  = 1'b1;
        WB_a_valid = 1'b0;
        WB_a_addr  = '0;
        WB_a_data  = '0;
        WB_b_valid = 1'b0;
        WB_b_addr  = '0;
        WB_b_data  = '0;
        ISS_set    = 1'b0;
        ISS_addr   = '0;
        HZ_addr1   = '0;
        HZ_addr2   = '0;
        HZ_addr3   = '0;
        @(posedge SYS_clk);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Contention: A then B alternate, first grant to A.
        repeat (4) applyStimulus(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, 0, 5'd3, 5'd4, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd4, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Write to register 0 is accepted and discarded.
        applyStimulus(0, 1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pending register 7, then B completes it.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd7);

        // Reissue to register 9 on the same edge its earlier result retires.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 0, 0);

        // Reset with a write in flight and register 5 pending.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0);
        applyStimulus(0, 1, 5'd2, 32'h5A5A, 0, 0, 0, 0, 0, 5'd5, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd2, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd2, 5'd9);

        // Random traffic; an unaccepted request is held stable until granted.
        lastAccA = 1'b0;
        lastAccB = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit          rst;
            bit          iss;
            logic [4:0]  ia;
            if (!rav || lastAccA) begin
                rav = ($urandom_range(0, 3) != 0);
                raa = 5'($urandom_range(0, 15));
                rad = $urandom;
            end
            if (!rbv || lastAccB) begin
                rbv = ($urandom_range(0, 2) != 0);
                rba = 5'($urandom_range(0, 15));
                rbd = $urandom;
            end
            rst = ($urandom_range(0, 63) == 0);
            iss = ($urandom_range(0, 3) == 0);
            ia  = 5'($urandom_range(0, 15));
            applyStimulus(rst, rav, raa, rad, rbv, rba, rbd, iss, ia,
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
